time_param_timer: RTL
=====================

// Module: time_param_timer
// PURPOSE
//   Parametrised successor of the alarm time-parameter bank: NUM_PARAMS programmable
//   delay registers of VALUE_W bits, loaded from DEFAULTS on reset, plus an integrated
//   countdown timer that runs the selected interval. Sits between the alarm FSM and
//   the user programming interface. The FSM starts, aborts and restarts timed intervals
//   and receives a one-cycle expiry pulse, so it no longer needs an external timer.
// PARAMETERS
//   NUM_PARAMS  4        number of time parameters (2..2**SEL_W)
//   VALUE_W     4        width of each parameter and of the countdown counter
//   SEL_W       2        width of select inputs
//   DEFAULTS    16'hAF86 packed reset values; param i = DEFAULTS[i*VALUE_W +: VALUE_W] (6,8,F,A)
//   TICK_DIV    4        clock cycles per timer unit (>=2; synthesis sets to clock Hz)
// PORTS
//   clock           in   1        rising-edge clock
//   reset           in   1        asynchronous, active-low reset
//   time_param_sel  in   SEL_W    parameter index to reprogram
//   time_value      in   VALUE_W  new parameter value
//   reprogram       in   1        write strobe, sampled each edge
//   prog_ack        out  1        1-cycle pulse: write accepted
//   prog_err        out  1        1-cycle pulse: write rejected
//   interval        in   SEL_W    parameter selected for value readout and timer start
//   value           out  VALUE_W  combinational bank[interval]; 0 if interval >= NUM_PARAMS
//   start_timer     in   1        load counter with bank[interval] and run
//   abort_timer     in   1        stop timer, no expiry
//   busy            out  1        timer in COUNT
//   expired         out  1        1-cycle pulse at end of interval
//   remaining       out  VALUE_W  current count, in timer units
// BEHAVIOUR
//   Reset (reset=0, async): bank <= DEFAULTS. Prescaler and counter <= 0. State IDLE.
//     busy, expired, prog_ack and prog_err <= 0. value follows the defaults immediately.
//   Programming: on an edge with reprogram=1:
//     - time_param_sel < NUM_PARAMS and time_value != 0: write the parameter; prog_ack=1 next cycle.
//     - Otherwise: no write; prog_err=1 next cycle.
//     - Zero is reserved and never stored. Back-to-back writes are accepted every cycle.
//   value is combinational. A write becomes visible on value the cycle after the edge.
//   Timer FSM, states IDLE / COUNT / EXPIRE:
//     IDLE, start_timer=1: cnt <= bank[interval] (pre-write value if reprogrammed same edge).
//       Prescaler <= 0. Go to COUNT. If the loaded value is 0 (interval out of range), go to EXPIRE.
//     COUNT: prescaler increments each edge.
//       At TICK_DIV-1 the prescaler wraps to 0 and cnt decrements.
//       Decrement from 1 to 0: go to EXPIRE.
//     EXPIRE: expired=1 for exactly one cycle, then IDLE. busy=0.
//     start_timer in COUNT or EXPIRE restarts the timer: reload, prescaler <= 0, go to COUNT.
//       An expiry already in EXPIRE still pulses.
//     abort_timer in any state: go to IDLE, cnt <= 0, no expired pulse.
//       If abort and start arrive together, abort wins.
//   Latency: with start sampled at edge E0, expired is high from edge E0 + v*TICK_DIV
//     for one cycle, where v = loaded value.
//   Reprogramming during COUNT does not alter the running count. No wrap-around: cnt never
//     decrements below 0.
//   busy = (state == COUNT). remaining = cnt (holds 0 in IDLE after expiry or abort).
//   Reset asserted mid-count: outputs clear asynchronously and no expired pulse is generated.
// TESTING (TICK_DIV=4 unless noted)
//   1 Release reset; sweep interval 0..3 -> value = 6,8,F,A; busy, expired, prog_ack, prog_err = 0.
//   2 reprogram sel=2 value=3 -> prog_ack pulse next cycle; interval=2 reads 3, others unchanged.
//     Write value=0 -> prog_err pulse, bank unchanged.
//   3 start_timer with interval=0 at E0 -> busy from E0; remaining steps 6..1 every 4 edges;
//     expired high for one cycle after E24, then busy=0.
//   4 start at E0, start again at E10 (interval=1) -> expired only after E10+32.
//     abort at E5 -> no expired pulse, remaining=0.
//     abort and start together -> IDLE.
//   5 NUM_PARAMS=3 override: reprogram sel=3 -> prog_err. start with interval=3 -> value=0,
//     expired pulse one cycle after start.
//   6 Drop reset at E7 of a count after reprogramming param0=2 -> busy and remaining clear
//     immediately, no expired pulse; param0 reads 6 again.

Source files
------------

// File: rtl/time_param_timer.sv
// Programmable time-parameter bank with an integrated countdown timer.
// The alarm FSM starts/aborts intervals here and gets a one-cycle expiry pulse.
module time_param_timer #(
    parameter int                              NUM_PARAMS = 4,
    parameter int                              VALUE_W    = 4,
    parameter int                              SEL_W      = 2,
    parameter logic [NUM_PARAMS*VALUE_W-1:0]   DEFAULTS   = 16'hAF86,
    parameter int                              TICK_DIV   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SEL_W-1:0]   time_param_sel,
    input  logic [VALUE_W-1:0] time_value,
    input  logic               reprogram,
    output logic               prog_ack,
    output logic               prog_err,
    input  logic [SEL_W-1:0]   interval,
    output logic [VALUE_W-1:0] value,
    input  logic               start_timer,
    input  logic               abort_timer,
    output logic               busy,
    output logic               expired,
    output logic [VALUE_W-1:0] remaining
);

    localparam int NUM_SLOTS = 1 << SEL_W;
    localparam int PRESC_W   = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;

    logic [VALUE_W-1:0] bank_reg [NUM_PARAMS];
    logic [VALUE_W-1:0] slot_value [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;
    logic write_ok;
    logic prog_ack_reg, prog_err_reg;

    state_t state_reg, state_next;
    logic [VALUE_W-1:0] cnt_reg, cnt_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;

    // Every select code maps to a slot; codes past NUM_PARAMS read 0 and reject writes.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi < NUM_PARAMS) begin : g_param
                assign slot_value[gi] = bank_reg[gi];
                assign slot_valid[gi] = 1'b1;
            end else begin : g_pad
                assign slot_value[gi] = '0;
                assign slot_valid[gi] = 1'b0;
            end
        end
    endgenerate

    assign write_ok = reprogram && slot_valid[time_param_sel] && (time_value != '0);
    assign value    = slot_value[interval];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                bank_reg[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
            end
            prog_ack_reg <= 1'b0;
            prog_err_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (write_ok && time_param_sel == SEL_W'(i)) begin
                    bank_reg[i] <= time_value;
                end
            end
            prog_ack_reg <= write_ok;
            prog_err_reg <= reprogram && !write_ok;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            presc_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            presc_reg <= presc_next;
        end
    end

    // Abort beats start; start reloads from the bank as it stood before this edge's write.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        presc_next = presc_reg;
        if (abort_timer) begin
            state_next = IDLE;
            cnt_next   = '0;
            presc_next = '0;
        end else if (start_timer) begin
            cnt_next   = value;
            presc_next = '0;
            state_next = (value == '0) ? EXPIRE : COUNT;
        end else begin
            case (state_reg)
                COUNT: begin
                    if (presc_reg == PRESC_LAST) begin
                        presc_next = '0;
                        if (cnt_reg <= VALUE_W'(1)) begin
                            cnt_next   = '0;
                            state_next = EXPIRE;
                        end else begin
                            cnt_next = cnt_reg - 1'b1;
                        end
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
                EXPIRE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy      = (state_reg == COUNT);
    assign expired   = (state_reg == EXPIRE);
    assign remaining = cnt_reg;
    assign prog_ack  = prog_ack_reg;
    assign prog_err  = prog_err_reg;

endmodule
